// File: rtl/shift_sequencer.sv
// shift_sequencer: command-driven controller for a 4-bit universal shift register.
// Each accepted command does one parallel load, then N shifts (0..7) either
// right or left. The serial input is a constant fill bit or, in rotate mode,
// the bit that the register is shifting out. A one-cycle done pulse follows.
//
// state   | meaning
// --------+----------------------------------------------------------------
// S_IDLE  | waiting for a command, cmd_ready high, register held
// S_LOAD  | one cycle, parallel-load the captured word (sel = 11)
// S_SHIFT | one shift per cycle until remaining_q reaches 1
// S_DONE  | one cycle, register held with final value, done pulse high
module shift_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_data,
    input  logic       cmd_dir,
    input  logic       cmd_rot,
    input  logic       cmd_fill,
    input  logic [2:0] cmd_count,
    input  logic [3:0] reg_q,
    output logic [1:0] sel,
    output logic [3:0] in_load,
    output logic       in,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] SEL_HOLD  = 2'b00;
    localparam logic [1:0] SEL_RIGHT = 2'b01;
    localparam logic [1:0] SEL_LEFT  = 2'b10;
    localparam logic [1:0] SEL_LOAD  = 2'b11;

    state_t     state_q, state_d;
    logic [3:0] data_q, data_d;
    logic       dir_q, dir_d;
    logic       rot_q, rot_d;
    logic       fill_q, fill_d;
    logic [2:0] count_q, count_d;
    logic [2:0] remaining_q, remaining_d;
    logic       accept;

    // Ready is gated by reset so nothing can be accepted while reset is low.
    assign cmd_ready = (state_q == S_IDLE) && reset;
    assign accept    = cmd_valid && cmd_ready;

    // State register; reset aborts any command in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Captured command fields and shift counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q      <= 4'b0000;
            dir_q       <= 1'b0;
            rot_q       <= 1'b0;
            fill_q      <= 1'b0;
            count_q     <= 3'd0;
            remaining_q <= 3'd0;
        end else begin
            data_q      <= data_d;
            dir_q       <= dir_d;
            rot_q       <= rot_d;
            fill_q      <= fill_d;
            count_q     <= count_d;
            remaining_q <= remaining_d;
        end
    end

    // Fields are only written on acceptance so they stay frozen for the command.
    always_comb begin
        data_d      = data_q;
        dir_d       = dir_q;
        rot_d       = rot_q;
        fill_d      = fill_q;
        count_d     = count_q;
        remaining_d = remaining_q;
        if (accept) begin
            data_d  = cmd_data;
            dir_d   = cmd_dir;
            rot_d   = cmd_rot;
            fill_d  = cmd_fill;
            count_d = cmd_count;
        end
        case (state_q)
            S_LOAD:  remaining_d = count_q;
            S_SHIFT: remaining_d = remaining_q - 3'd1;
            default: remaining_d = remaining_q;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (count_q == 3'd0) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (remaining_q == 3'd1) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Register control outputs; rotate feedback is a direct combinational path from reg_q.
    always_comb begin
        sel     = SEL_HOLD;
        in_load = 4'b0000;
        in      = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_LOAD: begin
                sel     = SEL_LOAD;
                in_load = data_q;
                busy    = 1'b1;
            end
            S_SHIFT: begin
                sel  = dir_q ? SEL_LEFT : SEL_RIGHT;
                busy = 1'b1;
                if (rot_q) begin
                    in = dir_q ? reg_q[3] : reg_q[0];
                end else begin
                    in = fill_q;
                end
            end
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                sel = SEL_HOLD;
            end
        endcase
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench: shift_sequencer driving a behavioural 4-bit universal register.
module tb_shift_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_data;
    logic       cmd_dir;
    logic       cmd_rot;
    logic       cmd_fill;
    logic [2:0] cmd_count;
    logic [3:0] reg_q = 4'b0000;
    logic [1:0] sel;
    logic [3:0] in_load;
    logic       in;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shift_sequencer dut (
        .clk      (clk),
        .reset    (reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_data (cmd_data),
        .cmd_dir  (cmd_dir),
        .cmd_rot  (cmd_rot),
        .cmd_fill (cmd_fill),
        .cmd_count(cmd_count),
        .reg_q    (reg_q),
        .sel      (sel),
        .in_load  (in_load),
        .in       (in),
        .busy     (busy),
        .done     (done)
    );

    // Universal shift register model (no reset of its own).
    always_ff @(posedge clk) begin
        case (sel)
            2'b01:   reg_q <= {in, reg_q[3:1]};
            2'b10:   reg_q <= {reg_q[2:0], in};
            2'b11:   reg_q <= in_load;
            default: reg_q <= reg_q;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_cmd(input logic [3:0] d, input logic dr, input logic rt,
                             input logic fl, input logic [2:0] cnt);
        cmd_valid = 1'b1;
        cmd_data  = d;
        cmd_dir   = dr;
        cmd_rot   = rt;
        cmd_fill  = fl;
        cmd_count = cnt;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        cmd_valid = 1'b0; cmd_data = 4'b0; cmd_dir = 1'b0; cmd_rot = 1'b0;
        cmd_fill = 1'b0; cmd_count = 3'd0;
        tick();
        tick();
        checks++;
        if ({sel, in_load, in, busy, done, cmd_ready} !== 10'b0) begin
            errors++;
            $display("FAIL reset_outputs: got sel=%b in_load=%b in=%b busy=%b done=%b ready=%b, expected all 0",
                     sel, in_load, in, busy, done, cmd_ready);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 1'b1 || sel !== 2'b00) begin
            errors++;
            $display("FAIL reset_release: got ready=%b sel=%b, expected ready=1 sel=00", cmd_ready, sel);
        end
        @(negedge clk);
    endtask

    task automatic test_load_only();
        drive_cmd(4'b1010, 1'b0, 1'b0, 1'b0, 3'd0);
        tick();
        cmd_valid = 1'b0;
        checks++;
        if (sel !== 2'b11 || in_load !== 4'b1010 || busy !== 1'b1 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL load_only_load: got sel=%b in_load=%b busy=%b ready=%b, expected 11 1010 1 0",
                     sel, in_load, busy, cmd_ready);
        end
        tick();
        checks++;
        if (done !== 1'b1 || reg_q !== 4'b1010 || sel !== 2'b00) begin
            errors++;
            $display("FAIL load_only_done: got done=%b reg_q=%b sel=%b, expected 1 1010 00", done, reg_q, sel);
        end
        tick();
        checks++;
        if (cmd_ready !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL load_only_ready: got ready=%b done=%b busy=%b, expected 1 0 0", cmd_ready, done, busy);
        end
        // Back-to-back: accepted three cycles after the previous accept.
        drive_cmd(4'b0011, 1'b0, 1'b0, 1'b0, 3'd0);
        tick();
        cmd_valid = 1'b0;
        checks++;
        if (sel !== 2'b11 || in_load !== 4'b0011) begin
            errors++;
            $display("FAIL back_to_back_load: got sel=%b in_load=%b, expected 11 0011", sel, in_load);
        end
        tick();
        checks++;
        if (done !== 1'b1 || reg_q !== 4'b0011) begin
            errors++;
            $display("FAIL back_to_back_done: got done=%b reg_q=%b, expected 1 0011", done, reg_q);
        end
        tick();
    endtask

    task automatic test_rotate_right();
        drive_cmd(4'b1010, 1'b0, 1'b1, 1'b1, 3'd1);
        tick();
        cmd_valid = 1'b0;
        tick();
        checks++;
        if (sel !== 2'b01 || reg_q !== 4'b1010 || in !== 1'b0 || in_load !== 4'b0000) begin
            errors++;
            $display("FAIL rot_right_shift: got sel=%b reg_q=%b in=%b in_load=%b, expected 01 1010 0 0000",
                     sel, reg_q, in, in_load);
        end
        tick();
        checks++;
        if (done !== 1'b1 || reg_q !== 4'b0101 || sel !== 2'b00) begin
            errors++;
            $display("FAIL rot_right_done: got done=%b reg_q=%b sel=%b, expected 1 0101 00", done, reg_q, sel);
        end
        tick();
    endtask

    task automatic test_fill_left();
        logic [3:0] exp_pre [3];
        exp_pre[0] = 4'b1010;
        exp_pre[1] = 4'b0101;
        exp_pre[2] = 4'b1011;
        drive_cmd(4'b1010, 1'b1, 1'b0, 1'b1, 3'd3);
        tick();
        // Changing inputs after acceptance must have no effect.
        drive_cmd(4'b0000, 1'b0, 1'b1, 1'b0, 3'd7);
        cmd_valid = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (sel !== 2'b10 || in !== 1'b1 || reg_q !== exp_pre[i]) begin
                errors++;
                $display("FAIL fill_left_shift%0d: got sel=%b in=%b reg_q=%b, expected 10 1 %b",
                         i, sel, in, reg_q, exp_pre[i]);
            end
            tick();
        end
        checks++;
        if (done !== 1'b1 || reg_q !== 4'b0111 || sel !== 2'b00) begin
            errors++;
            $display("FAIL fill_left_done: got done=%b reg_q=%b sel=%b, expected 1 0111 00", done, reg_q, sel);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int busy_cycles = 0;
        int done_seen = 0;
        drive_cmd(4'b1001, 1'b1, 1'b1, 1'b0, 3'd4);
        tick();
        // Second command held valid throughout the first.
        drive_cmd(4'b0110, 1'b0, 1'b0, 1'b0, 3'd0);
        for (int i = 0; i < 20 && busy === 1'b1; i++) begin
            busy_cycles++;
            checks++;
            if (cmd_ready !== 1'b0) begin
                errors++;
                $display("FAIL rot_left4_ready_busy: got ready=%b while busy, expected 0", cmd_ready);
            end
            if (done === 1'b1) begin
                done_seen++;
                checks++;
                if (reg_q !== 4'b1001) begin
                    errors++;
                    $display("FAIL rot_left4_result: got reg_q=%b, expected 1001", reg_q);
                end
            end
            tick();
        end
        checks++;
        if (busy_cycles != 6 || done_seen != 1) begin
            errors++;
            $display("FAIL rot_left4_busy: got busy_cycles=%0d done_pulses=%0d, expected 6 1", busy_cycles, done_seen);
        end
        checks++;
        if (cmd_ready !== 1'b1 || sel !== 2'b00) begin
            errors++;
            $display("FAIL pending_idle: got ready=%b sel=%b, expected 1 00", cmd_ready, sel);
        end
        tick();
        cmd_valid = 1'b0;
        checks++;
        if (sel !== 2'b11 || in_load !== 4'b0110) begin
            errors++;
            $display("FAIL pending_accept: got sel=%b in_load=%b, expected 11 0110", sel, in_load);
        end
        tick();
        checks++;
        if (done !== 1'b1 || reg_q !== 4'b0110) begin
            errors++;
            $display("FAIL pending_done: got done=%b reg_q=%b, expected 1 0110", done, reg_q);
        end
        tick();
    endtask

    task automatic test_reset_mid_shift();
        drive_cmd(4'b1100, 1'b0, 1'b0, 1'b0, 3'd5);
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (sel !== 2'b01 || reg_q !== 4'b0110) begin
            errors++;
            $display("FAIL abort_pre: got sel=%b reg_q=%b, expected 01 0110", sel, reg_q);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({sel, in_load, in, busy, done, cmd_ready} !== 10'b0) begin
            errors++;
            $display("FAIL abort_async: got sel=%b in_load=%b in=%b busy=%b done=%b ready=%b, expected all 0",
                     sel, in_load, in, busy, done, cmd_ready);
        end
        tick();
        checks++;
        if (reg_q !== 4'b0110 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_hold: got reg_q=%b busy=%b, expected 0110 0", reg_q, busy);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 1'b1 || sel !== 2'b00) begin
            errors++;
            $display("FAIL abort_release: got ready=%b sel=%b, expected 1 00", cmd_ready, sel);
        end
        @(negedge clk);
        drive_cmd(4'b0110, 1'b1, 1'b1, 1'b0, 3'd2);
        tick();
        cmd_valid = 1'b0;
        checks++;
        if (sel !== 2'b11 || in_load !== 4'b0110) begin
            errors++;
            $display("FAIL after_abort_load: got sel=%b in_load=%b, expected 11 0110", sel, in_load);
        end
        tick();
        tick();
        tick();
        checks++;
        if (done !== 1'b1 || reg_q !== 4'b1001) begin
            errors++;
            $display("FAIL after_abort_done: got done=%b reg_q=%b, expected 1 1001", done, reg_q);
        end
        tick();
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL after_abort_idle: got ready=%b busy=%b, expected 1 0", cmd_ready, busy);
        end
    endtask

    initial begin
        test_reset();
        test_load_only();
        test_rotate_right();
        test_fill_left();
        test_back_to_back();
        test_reset_mid_shift();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Command-driven controller placed directly upstream of the 4-bit `universal` shift register. It accepts one load-and-shift command per valid/ready handshake. For each command it drives the register's `sel`, `in_load` and `in` inputs cycle by cycle: one parallel load, then N shifts in the chosen direction with either a constant fill bit or rotate feedback from the register output. It pulses `done` when the register holds the final value.

## Interface
Parameters:
- none (register width fixed at 4, shift count fixed at 3 bits)

Ports:
- `clk`  in  1  single clock, rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  sequencer can accept a command.
- `cmd_data`  in  4  word to parallel-load.
- `cmd_dir`  in  1  0 = shift right, 1 = shift left.
- `cmd_rot`  in  1  1 = rotate (feedback from `reg_q`), 0 = fill with `cmd_fill`.
- `cmd_fill`  in  1  serial fill bit when `cmd_rot`=0.
- `cmd_count`  in  3  number of shifts after the load (0–7).
- `reg_q`  in  4  `out` of the driven universal register.
- `sel`  out  2  to register: 00 hold, 01 shift right (serial in enters bit 3), 10 shift left (serial in enters bit 0), 11 parallel load.
- `in_load`  out  4  to register parallel input.
- `in`  out  1  to register serial input.
- `busy`  out  1  command in progress.
- `done`  out  1  one-cycle completion pulse.

## Operation
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - `cmd_ready`=1, `sel`=00, `in_load`=0000, `in`=0.
  - On `cmd_valid && cmd_ready` at a rising edge, capture `cmd_data`, `cmd_dir`, `cmd_rot`, `cmd_fill` and `cmd_count` into internal registers. Go to LOAD.
- LOAD: exactly one cycle.
  - `sel`=11, `in_load`=captured data, `in`=0.
  - Next state: DONE if captured count = 0; otherwise SHIFT, with `remaining` = count.
- SHIFT:
  - `sel`=01 if dir=0, 10 if dir=1. `in_load`=0000.
  - `in` in fill mode = captured fill.
  - `in` in rotate mode = `reg_q[0]` for right, `reg_q[3]` for left. This is a combinational path from `reg_q`.
  - `remaining` decrements each cycle. Leave SHIFT for DONE in the cycle where `remaining`=1.
- DONE: one cycle, `sel`=00, `done`=1. Go to IDLE.
- `busy` = 1 in LOAD, SHIFT and DONE.
- `cmd_ready` = (state == IDLE) AND `reset`. It is never combinationally dependent on `cmd_valid`.
- `cmd_valid` asserted while busy is ignored. The command stays pending on the input until the next IDLE cycle.
- Captured fields are frozen for the whole command. Input changes after acceptance have no effect.
- Rotate by 4 returns the original word. Counts 5–7 are legal and execute literally.

## Timing
- Handshake accepted at edge k:
  - LOAD occupies cycle k→k+1, and the register holds the data after edge k+1.
  - The shifts occupy N cycles; the register holds the final value after edge k+1+N.
  - DONE is high in cycle k+1+N→k+2+N.
  - `cmd_ready` rises at edge k+2+N.
- Accept-to-accept spacing is N+3 cycles. Maximum throughput: one command every 3 cycles (N=0).
- When `done` is high, `reg_q` already equals the final result and `sel`=00 keeps it stable.
- Reset asserted (low) at any time, including mid-SHIFT:
  - immediately forces IDLE;
  - `sel`=00, `in_load`=0000, `in`=0, `busy`=0, `done`=0, `cmd_ready`=0;
  - all captured fields and `remaining` cleared.
- After reset deasserts, `cmd_ready`=1, and the first accept can occur at the next edge.
- An aborted command is never resumed.

## Test plan
The bench instantiates `shift_sequencer` driving a real `universal` register, with `reg_q` tied to its `out`.
- Reset held low 2 cycles → all outputs 0, `cmd_ready`=0. After release, `cmd_ready`=1 and `sel`=00.
- Load-only: data=1010, count=0 → `sel`=11 for 1 cycle, then `done`=1 with `reg_q`=1010, then `cmd_ready`=1. Accept-to-accept is 3 cycles.
- Rotate right 1: data=1010, dir=0, rot=1, count=1 → `reg_q` 1010→0101. `done` is high 3 cycles after accept.
- Fill left 3: data=1010, dir=1, rot=0, fill=1, count=3 → `reg_q` 1010→0101→1011→0111, `sel`=10 for exactly 3 cycles.
- Rotate left 4: data=1001 → final `reg_q`=1001, `busy` high for 6 cycles. A second `cmd_valid` held throughout is accepted only at the edge after DONE.
- Reset pulse during the 2nd shift of a count=5 command → outputs clear asynchronously and `reg_q` is not shifted further. A new load of 0110 afterwards completes correctly.
